count_seq_ctrl: RTL and testbench

//   Run/pause/direction controller for the 4-bit binary counter on the DE board.

---
 rtl/count_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_count_seq_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_ctrl.sv
// Run/pause/direction controller for a WIDTH-bit counter stepped by a CLK_HZ/TICK_HZ divider.
// Pushbuttons are synchronised and edge-detected; same-cycle priority is load > start/pause > step > tick.
module count_seq_ctrl #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int WIDTH   = 4
) (
  input  logic             CLOCK_50,
  input  logic             RS,
  input  logic [3:0]       KEY,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] LEDR,
  output logic [2:0]       LEDG,
  output logic             tick_o
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]    DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0]    DIV_PEN  = DW'(DIV - 2);
  localparam logic [DW-1:0]    DIV_ONE  = DW'(1);
  localparam logic [DW-1:0]    DIV_ZERO = DW'(0);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t           r_state;
  logic [3:0]       r_key_meta;
  logic [3:0]       r_key_sync;
  logic [3:0]       r_key_dly;
  logic [3:0]       r_press;
  logic [DW-1:0]    r_div;
  logic [WIDTH-1:0] r_cnt;
  logic             r_dir;
  logic             r_wrap;
  logic             r_run;
  logic             r_tick;
  logic             w_term;
  logic             w_step_cmd;
  logic [WIDTH:0]   w_stepped;

  // Returns {wrapped, next value} for one count step in the given direction.
  function automatic logic [WIDTH:0] step_count(input logic [WIDTH-1:0] v, input logic down);
    if (down) begin
      step_count = {(v == CNT_ZERO), v - CNT_ONE};
    end else begin
      step_count = {(v == CNT_MAX), v + CNT_ONE};
    end
  endfunction

  assign w_term     = (r_state == ST_RUN) && (r_div == DIV_LAST);
  assign w_step_cmd = r_press[3] && (r_state != ST_RUN);
  assign w_stepped  = step_count(r_cnt, r_dir);

  // Press pulse is registered so it appears three clocks after the pin falls.
  always_ff @(posedge CLOCK_50 or posedge RS) begin
    if (RS) begin
      r_key_meta <= 4'hF;
      r_key_sync <= 4'hF;
      r_key_dly  <= 4'hF;
      r_press    <= 4'h0;
    end else begin
      r_key_meta <= KEY;
      r_key_sync <= r_key_meta;
      r_key_dly  <= r_key_sync;
      r_press    <= r_key_dly & ~r_key_sync;
    end
  end

  // Sequencer: tick_o is set one cycle early so it coincides with r_div == DIV-1.
  always_ff @(posedge CLOCK_50 or posedge RS) begin
    if (RS) begin
      r_state <= ST_IDLE;
      r_div   <= DIV_ZERO;
      r_cnt   <= CNT_ZERO;
      r_dir   <= 1'b0;
      r_wrap  <= 1'b0;
      r_run   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      if (r_press[1]) begin
        r_dir <= ~r_dir;
      end
      if (r_press[2]) begin
        r_cnt  <= SW;
        r_wrap <= 1'b0;
        r_div  <= DIV_ZERO;
        r_tick <= 1'b0;
      end else if (r_press[0]) begin
        r_div  <= DIV_ZERO;
        r_tick <= 1'b0;
        case (r_state)
          ST_IDLE, ST_PAUSE: begin
            r_state <= ST_RUN;
            r_run   <= 1'b1;
          end
          ST_RUN: begin
            r_state <= ST_PAUSE;
            r_run   <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_run   <= 1'b0;
          end
        endcase
      end else if (w_step_cmd || w_term) begin
        r_wrap <= w_stepped[WIDTH];
        r_cnt  <= w_stepped[WIDTH-1:0];
        r_div  <= DIV_ZERO;
        r_tick <= 1'b0;
      end else if (r_state == ST_RUN) begin
        r_div  <= r_div + DIV_ONE;
        r_tick <= (r_div == DIV_PEN);
      end else begin
        r_div  <= DIV_ZERO;
        r_tick <= 1'b0;
      end
    end
  end

  assign LEDR   = r_cnt;
  assign LEDG   = {r_wrap, r_dir, r_run};
  assign tick_o = r_tick;
endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl with DIV=10: vector table, hand-written corner sequences,
// and random key activity, all checked every cycle against an arithmetic reference model.
module tb_count_seq_ctrl;
  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 1;
  localparam int WIDTH   = 4;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int MODV    = 16;

  logic       clk = 1'b0;
  logic       rs  = 1'b1;
  logic [3:0] key = 4'hF;
  logic [3:0] sw  = 4'h0;
  logic [3:0] ledr;
  logic [2:0] ledg;
  logic       tick;

  always #5 clk = ~clk;

  count_seq_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .WIDTH(WIDTH)) dut (
    .CLOCK_50(clk), .RS(rs), .KEY(key), .SW(sw),
    .LEDR(ledr), .LEDG(ledg), .tick_o(tick)
  );

  int n_vec  = 0;
  int n_err  = 0;
  int cyc_no = 0;

  // Reference model: mode 0 idle, 1 run, 2 pause; phase = clocks since the period restarted.
  int         m_mode;
  int         m_cnt;
  int         m_phase;
  bit         m_dir;
  bit         m_wrap;
  logic [3:0] m_hist [4];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc_no, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_phase = 0; m_dir = 1'b0; m_wrap = 1'b0;
    for (int i = 0; i < 4; i++) m_hist[i] = 4'hF;
  endtask

  task automatic model_count();
    if (m_dir) begin
      m_wrap = (m_cnt == 0);
      m_cnt  = (m_cnt + MODV - 1) % MODV;
    end else begin
      m_wrap = (m_cnt == MODV - 1);
      m_cnt  = (m_cnt + 1) % MODV;
    end
  endtask

  task automatic model_step();
    logic [3:0] p;
    bit term;
    bit ndir;
    p    = m_hist[3] & ~m_hist[2];
    term = (m_mode == 1) && (m_phase == DIV - 1);
    ndir = p[1] ? ~m_dir : m_dir;
    if (p[2]) begin
      m_cnt = int'(sw); m_wrap = 1'b0; m_phase = 0;
    end else if (p[0]) begin
      m_mode = (m_mode == 1) ? 2 : 1; m_phase = 0;
    end else if ((p[3] && m_mode != 1) || term) begin
      model_count(); m_phase = 0;
    end else begin
      m_phase = (m_mode == 1) ? m_phase + 1 : 0;
    end
    m_dir = ndir;
    m_hist[3] = m_hist[2]; m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = key;
  endtask

  function automatic logic [7:0] model_out();
    return {m_cnt[3:0], m_wrap, m_dir, (m_mode == 1), (m_mode == 1 && m_phase == DIV - 1)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (rs) model_reset();
    else model_step();
    @(negedge clk);
    cyc_no++;
    chk("cycle", int'({ledr, ledg, tick}), int'(model_out()));
  endtask

  task automatic press(input logic [3:0] mask);
    key = ~mask;
    cyc(); cyc();
    key = 4'hF;
    cyc(); cyc();
  endtask

  task automatic wait_change(output int n);
    logic [3:0] v;
    v = ledr;
    n = 0;
    while (ledr == v && n < 4 * DIV) begin
      cyc(); n++;
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (!tick && n < 4 * DIV) begin
      cyc(); n++;
    end
    chk("tick_seen", int'(tick), 1);
  endtask

  typedef struct {
    logic [3:0] mask;
    logic [3:0] sw;
    logic [3:0] ledr;
    logic [2:0] ledg;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int n;
    tbl[0]  = '{4'b1000, 4'h3, 4'h1, 3'b000};
    tbl[1]  = '{4'b0010, 4'h3, 4'h1, 3'b010};
    tbl[2]  = '{4'b1000, 4'h3, 4'h0, 3'b010};
    tbl[3]  = '{4'b1000, 4'h3, 4'hF, 3'b110};
    tbl[4]  = '{4'b0100, 4'h5, 4'h5, 3'b010};
    tbl[5]  = '{4'b1010, 4'h3, 4'h4, 3'b000};
    tbl[6]  = '{4'b1000, 4'h3, 4'h5, 3'b000};
    tbl[7]  = '{4'b1100, 4'hF, 4'hF, 3'b000};
    tbl[8]  = '{4'b1000, 4'h3, 4'h0, 3'b100};
    tbl[9]  = '{4'b0101, 4'hA, 4'hA, 3'b000};
    tbl[10] = '{4'b0001, 4'h3, 4'hA, 3'b001};
    tbl[11] = '{4'b1000, 4'h3, 4'hA, 3'b001};
    tbl[12] = '{4'b0001, 4'h3, 4'hA, 3'b000};
    tbl[13] = '{4'b1000, 4'h3, 4'hB, 3'b000};

    model_reset();
    repeat (3) cyc();
    chk("reset_ledr", int'(ledr), 0);
    chk("reset_ledg", int'(ledg), 0);
    chk("reset_tick", int'(tick), 0);
    rs = 1'b0;
    cyc();

    for (int i = 0; i < 14; i++) begin
      sw = tbl[i].sw;
      press(tbl[i].mask);
      chk($sformatf("vec%0d_ledr", i), int'(ledr), int'(tbl[i].ledr));
      chk($sformatf("vec%0d_ledg", i), int'(ledg), int'(tbl[i].ledg));
    end

    // Wrap while running, and exact step spacing after start.
    sw = 4'hF;
    press(4'b0100);
    press(4'b0001);
    chk("run_led", int'(ledg[0]), 1);
    wait_change(n);
    chk("first_step_latency", n, DIV);
    chk("wrap_ledr", int'(ledr), 0);
    chk("wrap_ledg", int'(ledg), 3'b101);
    wait_change(n);
    chk("second_step_latency", n, DIV);
    chk("after_wrap_ledr", int'(ledr), 1);
    chk("after_wrap_ledg", int'(ledg), 3'b001);

    // Pause mid-period, single-step three times, resume.
    repeat (3) cyc();
    press(4'b0001);
    chk("pause_ledg", int'(ledg), 3'b000);
    chk("pause_ledr", int'(ledr), 1);
    repeat (3) press(4'b1000);
    chk("paused_steps", int'(ledr), 4);
    press(4'b0001);
    wait_change(n);
    chk("resume_latency", n, DIV);
    chk("resume_ledr", int'(ledr), 5);

    // Load pulse lands exactly on a tick cycle.
    wait_tick();
    repeat (7) cyc();
    sw = 4'h7;
    key = 4'b1011;
    cyc(); cyc();
    key = 4'hF;
    cyc(); cyc();
    chk("load_on_tick_ledr", int'(ledr), 7);
    chk("load_on_tick_ledg", int'(ledg), 3'b001);
    wait_change(n);
    chk("load_restart_latency", n, DIV);
    chk("load_restart_ledr", int'(ledr), 8);

    // A long hold gives one toggle only.
    key = 4'hE;
    repeat (50) cyc();
    key = 4'hF;
    repeat (5) cyc();
    chk("hold_single_toggle", int'(ledg[0]), 0);

    // Asynchronous reset between clock edges while running.
    press(4'b0001);
    repeat (25) cyc();
    #2 rs = 1'b1;
    #1;
    chk("async_rst_ledr", int'(ledr), 0);
    chk("async_rst_ledg", int'(ledg), 0);
    chk("async_rst_tick", int'(tick), 0);
    cyc(); cyc();
    rs = 1'b0;
    repeat (30) cyc();
    chk("post_rst_ledr", int'(ledr), 0);
    chk("post_rst_ledg", int'(ledg), 0);

    for (int i = 0; i < 1500; i++) begin
      sw = 4'($urandom_range(0, 15));
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 19) == 0) key[b] = ~key[b];
      end
      cyc();
    end
    key = 4'hF;
    repeat (5) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
